serial_comp_ctrl: RTL and testbench
===================================

SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: start  input  1  request a new comparison; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 Port: busy  output  1  high in SCAN and DONE; low in IDLE.
REQ-008 Port: done  output  1  one-cycle pulse when the result becomes valid.
REQ-009 Port: gt  output  1  A > B (unsigned).
REQ-010 Port: lt  output  1  A < B (unsigned).
REQ-011 Port: eq  output  1  A == B.
REQ-012 Port: bits_examined  output  clog2(WIDTH+1)  count of bit positions evaluated for the current/last result.

Function
REQ-013 The block SHALL compare A and B MSB-first, evaluating exactly one bit position per clock through a single 1-bit compare cell.
REQ-014 FSM states SHALL be IDLE, SCAN, DONE; all outputs SHALL be registered.
REQ-015 IDLE and start=1: capture a/b, set bit index to WIDTH-1, clear gt/lt/eq and bits_examined to 0, go to SCAN.
REQ-016 IDLE and start=0: remain in IDLE; gt/lt/eq/bits_examined hold their last values.
REQ-017 SCAN: each edge SHALL evaluate the bit at the current index and increment bits_examined by 1.
REQ-018 SCAN, bits differ: set gt=1 (A bit 1) or lt=1 (B bit 1) and go to DONE; early termination.
REQ-019 SCAN, bits equal, index 0: set eq=1 and go to DONE.
REQ-020 SCAN, bits equal, index > 0: decrement index and stay in SCAN.
REQ-021 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-022 Latency: done SHALL be high k cycles after the accepting edge, where k = WIDTH-i and i is the highest differing bit index, or k = WIDTH if A == B.
REQ-023 gt, lt and eq SHALL be mutually exclusive at all times and exactly one-hot from the DONE cycle until the next accepted start.
REQ-024 start SHALL be ignored in SCAN and DONE; captured operands SHALL not change while busy.
REQ-025 Changes on a/b outside the accepting edge SHALL not affect the result.
REQ-026 WIDTH=1: a single SCAN cycle, so done is high 1 cycle after acceptance.

Reset
REQ-027 With rst=1 at an edge: state = IDLE; busy, done, gt, lt, eq, bits_examined, operand registers and index all = 0.
REQ-028 rst SHALL take priority over start and over any SCAN/DONE activity.
REQ-029 Reset mid-operation SHALL abort the comparison with no done pulse.
REQ-030 start with rst=1 on the same edge SHALL be discarded.

Structure
REQ-031 State encodings (IDLE=2'd0, SCAN=2'd1, DONE=2'd2) SHALL be localparams in the shared package comp_pkg, alongside the result one-hot bit positions.
REQ-032 The per-bit compare SHALL be a sub-module bit_comp_cell with inputs x, y and outputs gt, lt, eq; it SHALL be purely combinational and instantiated exactly once.
REQ-033 The controller SHALL contain no WIDTH-wide magnitude comparator; only the index/counter logic scales with WIDTH.

Verification (WIDTH=8)
REQ-034 a=8'hA5, b=8'h25, start pulse → done 1 cycle later; gt=1, lt=0, eq=0, bits_examined=1.
REQ-035 a=8'h3C, b=8'h3D → done 8 cycles after acceptance; lt=1, bits_examined=8.
REQ-036 a=b=8'hFF → done after 8 cycles; eq=1, bits_examined=8; a second start with a=8'h00, b=8'h80 → flags cleared on the accepting edge, then lt=1 after 1 cycle.
REQ-037 a=8'h10, b=8'h01; start re-asserted every cycle of SCAN with a/b changed to 8'h00 → exactly one done pulse after 4 cycles; gt=1; no second comparison begins until after DONE.
REQ-038 rst asserted on the 3rd SCAN cycle of a=b=8'h55 → next cycle all outputs 0, state IDLE, and no done pulse in the following 10 cycles.
REQ-039 Random a/b sweep (≥1000 pairs, including WIDTH=1 build) → flags match an unsigned reference compare and the REQ-022 latency holds for every pair.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared encodings for the serial comparator: FSM states and the
// bit positions of the one-hot result vector.
package comp_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int RES_GT = 0;
   localparam int RES_LT = 1;
   localparam int RES_EQ = 2;
   localparam int RES_W  = 3;
endpackage

// File: rtl/bit_comp_cell.sv
// Single-bit magnitude compare cell; the controller walks operands through it
// one bit position per clock.
module bit_comp_cell (
   input  logic x,
   input  logic y,
   output logic gt,
   output logic lt,
   output logic eq
);
   assign gt = x & ~y;
   assign lt = ~x & y;
   assign eq = ~(x ^ y);
endmodule

// File: rtl/serial_comp_ctrl.sv
// MSB-first serial unsigned comparator: one bit per clock through a shared
// 1-bit cell, terminating early on the first differing bit.
//
// state | meaning
// IDLE  | waiting for start; result flags and count hold last values
// SCAN  | evaluating bit a_q[idx] vs b_q[idx] each edge
// DONE  | result valid, one-cycle done pulse
module serial_comp_ctrl
   import comp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   output logic                         busy,
   output logic                         done,
   output logic                         gt,
   output logic                         lt,
   output logic                         eq,
   output logic [$clog2(WIDTH+1)-1:0]   bits_examined
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = $clog2(WIDTH+1);
   localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH-1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt;
   logic [RES_W-1:0] res;
   logic             busy_nxt;
   logic             done_nxt;
   logic             cell_gt;
   logic             cell_lt;
   logic             cell_eq;
   logic             last_bit;

   assign last_bit = (idx == '0);

   bit_comp_cell u_cell (
      .x  (a_q[idx]),
      .y  (b_q[idx]),
      .gt (cell_gt),
      .lt (cell_lt),
      .eq (cell_eq)
   );

   // busy/done are registered from the next state so they line up with state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_SCAN;
         ST_SCAN: if (!cell_eq || last_bit) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_nxt = (state_nxt != ST_IDLE);
      done_nxt = (state_nxt == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         idx <= '0;
         cnt <= '0;
         res <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_q <= a;
                  b_q <= b;
                  idx <= IDX_TOP;
                  cnt <= '0;
                  res <= '0;
               end
            end
            ST_SCAN: begin
               cnt <= cnt + CW'(1);
               if (cell_gt) begin
                  res         <= '0;
                  res[RES_GT] <= 1'b1;
               end else if (cell_lt) begin
                  res         <= '0;
                  res[RES_LT] <= 1'b1;
               end else if (last_bit) begin
                  res         <= '0;
                  res[RES_EQ] <= 1'b1;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign gt            = res[RES_GT];
   assign lt            = res[RES_LT];
   assign eq            = res[RES_EQ];
   assign bits_examined = cnt;
endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Bench for serial_comp_ctrl: WIDTH=8 and WIDTH=1 instances checked every cycle
// against a latency/flag model, plus directed literal expectations.
module tb_serial_comp_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0 = 1'b1, start0 = 1'b0;
   logic [7:0] a0 = '0, b0 = '0;
   logic       busy0, done0, gt0, lt0, eq0;
   logic [3:0] be0;

   logic       rst1 = 1'b1, start1 = 1'b0;
   logic       a1 = 1'b0, b1 = 1'b0;
   logic       busy1, done1, gt1, lt1, eq1;
   logic [0:0] be1;

   serial_comp_ctrl #(.WIDTH(8)) dut0 (
      .clk(clk), .rst(rst0), .start(start0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .gt(gt0), .lt(lt0), .eq(eq0),
      .bits_examined(be0)
   );

   serial_comp_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1),
      .bits_examined(be1)
   );

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Cycles from acceptance to done: WIDTH minus the highest differing bit index.
   function automatic int calc_k(input logic [31:0] av, input logic [31:0] bv, input int w);
      for (int i = w - 1; i >= 0; i--)
         if (av[i] != bv[i]) return w - i;
      return w;
   endfunction

   bit m_busy [2], m_done [2], m_gt [2], m_lt [2], m_eq [2];
   bit p_gt [2], p_lt [2], p_eq [2];
   int m_cnt [2], m_k [2];

   logic        s_rst   [2] = '{1'b1, 1'b1};
   logic        s_start [2] = '{1'b0, 1'b0};
   logic [31:0] s_a [2];
   logic [31:0] s_b [2];

   always @(posedge clk) begin
      s_rst[0]   <= rst0;
      s_start[0] <= start0;
      s_a[0]     <= {24'b0, a0};
      s_b[0]     <= {24'b0, b0};
      s_rst[1]   <= rst1;
      s_start[1] <= start1;
      s_a[1]     <= {31'b0, a1};
      s_b[1]     <= {31'b0, b1};
   end

   task automatic step(input int u, input logic r, input logic s,
                       input logic [31:0] av_in, input logic [31:0] bv_in, input int w);
      logic [31:0] mask, av, bv;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      av = av_in & mask;
      bv = bv_in & mask;
      if (r === 1'b1) begin
         m_busy[u] = 0; m_done[u] = 0; m_gt[u] = 0; m_lt[u] = 0; m_eq[u] = 0;
         m_cnt[u] = 0;
      end else if (!m_busy[u]) begin
         if (s === 1'b1) begin
            m_busy[u] = 1; m_gt[u] = 0; m_lt[u] = 0; m_eq[u] = 0; m_cnt[u] = 0;
            m_k[u] = calc_k(av, bv, w);
            p_gt[u] = (av > bv); p_lt[u] = (av < bv); p_eq[u] = (av == bv);
         end
      end else if (m_done[u]) begin
         m_done[u] = 0;
         m_busy[u] = 0;
      end else begin
         m_cnt[u]++;
         if (m_cnt[u] == m_k[u]) begin
            m_done[u] = 1;
            m_gt[u] = p_gt[u]; m_lt[u] = p_lt[u]; m_eq[u] = p_eq[u];
         end
      end
   endtask

   always @(negedge clk) begin
      step(0, s_rst[0], s_start[0], s_a[0], s_b[0], 8);
      step(1, s_rst[1], s_start[1], s_a[1], s_b[1], 1);
      if (chk_en) begin
         chk("cyc_w8", {busy0, done0, gt0, lt0, eq0, be0},
             {m_busy[0], m_done[0], m_gt[0], m_lt[0], m_eq[0], 4'(m_cnt[0])});
         chk("cyc_w1", {busy1, done1, gt1, lt1, eq1, be1},
             {m_busy[1], m_done[1], m_gt[1], m_lt[1], m_eq[1], 1'(m_cnt[1])});
      end
   end

   task automatic drive(input int u, input logic s, input logic [31:0] av, input logic [31:0] bv);
      if (u == 0) begin
         start0 = s; a0 = av[7:0]; b0 = bv[7:0];
      end else begin
         start1 = s; a1 = av[0]; b1 = bv[0];
      end
   endtask

   // Returns cycles from the accepting edge until done is seen (40 = timeout).
   task automatic run_pair(input int u, input logic [31:0] av, input logic [31:0] bv, output int n);
      @(negedge clk);
      drive(u, 1'b1, av, bv);
      @(negedge clk);
      drive(u, 1'b0, $urandom, $urandom);
      if (u == 0) chk("clr_on_accept", {gt0, lt0, eq0, be0}, 32'h0);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         n++;
         if ((u == 0) ? done0 : done1) break;
      end
   endtask

   task automatic dir(input string nm, input logic [7:0] av, input logic [7:0] bv,
                      input int k, input logic [2:0] flags, input int bits);
      int n;
      run_pair(0, {24'b0, av}, {24'b0, bv}, n);
      chk({nm, "_lat"}, n, k);
      chk({nm, "_flags"}, {gt0, lt0, eq0}, {29'b0, flags});
      chk({nm, "_bits"}, be0, bits);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, pulses;
      logic [31:0] av, bv;

      repeat (2) @(negedge clk);
      chk("reset_w8", {busy0, done0, gt0, lt0, eq0, be0}, 32'h0);
      chk("reset_w1", {busy1, done1, gt1, lt1, eq1, be1}, 32'h0);
      rst0 = 1'b0;
      rst1 = 1'b0;
      chk_en = 1'b1;

      dir("a5_25", 8'hA5, 8'h25, 1, 3'b100, 1);
      dir("3c_3d", 8'h3C, 8'h3D, 8, 3'b010, 8);
      dir("ff_ff", 8'hFF, 8'hFF, 8, 3'b001, 8);
      dir("00_80", 8'h00, 8'h80, 1, 3'b010, 1);
      repeat (3) @(negedge clk);
      chk("hold_idle", {gt0, lt0, eq0, be0}, {25'b0, 3'b010, 4'd1});

      // start held high through SCAN with operands changing
      @(negedge clk);
      drive(0, 1'b1, 32'h10, 32'h01);
      @(negedge clk);
      drive(0, 1'b1, 32'h0, 32'h0);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         n++;
         if (done0) begin
            drive(0, 1'b0, 32'h0, 32'h0);
            break;
         end
         drive(0, 1'b1, 32'h0, 32'h0);
      end
      chk("restart_lat", n, 4);
      chk("restart_flags", {gt0, lt0, eq0}, 32'b100);
      @(negedge clk);
      chk("restart_idle", busy0, 0);
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (done0) pulses++;
      end
      chk("restart_one_done", pulses, 0);

      // reset during the third SCAN cycle
      @(negedge clk);
      drive(0, 1'b1, 32'h55, 32'h55);
      @(negedge clk);
      drive(0, 1'b0, 32'h55, 32'h55);
      repeat (2) @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      chk("midrst_outs", {busy0, done0, gt0, lt0, eq0, be0}, 32'h0);
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (done0) pulses++;
      end
      chk("midrst_no_done", pulses, 0);

      for (int i = 0; i < 1000; i++) begin
         av = 32'($urandom_range(0, 255));
         bv = (i % 8 == 0) ? av : 32'($urandom_range(0, 255));
         run_pair(0, av, bv, n);
         chk("rnd8_lat", n, calc_k(av, bv, 8));
         chk("rnd8_flags", {gt0, lt0, eq0}, {29'b0, av > bv, av < bv, av == bv});
      end

      for (int i = 0; i < 1000; i++) begin
         av = 32'($urandom_range(0, 1));
         bv = 32'($urandom_range(0, 1));
         run_pair(1, av, bv, n);
         chk("rnd1_lat", n, 1);
         chk("rnd1_flags", {gt1, lt1, eq1}, {29'b0, av > bv, av < bv, av == bv});
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
